// File: rtl/fsm_counter_pkg.sv
// Shared types for the run-N-cycles sequencer: state encoding and default counter width.
package fsm_counter_pkg;

  localparam int CNT_WIDTH_DEF = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fsm_counter_if.sv
// Start request / count and the three Moore status flags of the run-N-cycles sequencer.
interface fsm_counter_if
  import fsm_counter_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
);

  logic                 i_run;
  logic [CNT_WIDTH-1:0] i_num_cnt;
  logic                 o_idle;
  logic                 o_running;
  logic                 o_done;

  modport master (
    output i_run, i_num_cnt,
    input  o_idle, o_running, o_done
  );

  modport slave (
    input  i_run, i_num_cnt,
    output o_idle, o_running, o_done
  );

endinterface

// File: rtl/fsm_cycle_counter.sv
// Latched run length plus cycle counter; o_is_last flags the final RUN cycle.
// Load captures the count and restarts the counter; no handshake, controlled entirely by the FSM.
module fsm_cycle_counter
  import fsm_counter_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [CNT_WIDTH-1:0] i_num_cnt,
  output logic                 o_is_last
);

  logic [CNT_WIDTH-1:0] r_num;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_last_val;

  // A zero count never reaches RUN, so the underflow of r_num-1 is never observed.
  assign w_last_val = r_num - CNT_WIDTH'(1);
  assign o_is_last  = (r_cnt == w_last_val);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_num <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_num <= i_num_cnt;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fsm_counter.sv
// IDLE/RUN/DONE sequencer: an accepted i_run gives N cycles of o_running, then one o_done.
// o_done follows the accepting edge by N+1 cycles; i_run is ignored outside IDLE (no queuing).
module fsm_counter
  import fsm_counter_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  fsm_counter_if.slave bus
);

  state_t r_state;
  state_t w_next_state;
  logic   w_load;
  logic   w_clr;
  logic   w_en;
  logic   w_is_last;

  fsm_cycle_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_clr     (w_clr),
    .i_en      (w_en),
    .i_num_cnt (bus.i_num_cnt),
    .o_is_last (w_is_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_clr        = 1'b0;
    w_en         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_run) begin
          w_load       = 1'b1;
          w_next_state = (bus.i_num_cnt == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_is_last) begin
          w_clr        = 1'b1;
          w_next_state = S_DONE;
        end else begin
          w_en = 1'b1;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign bus.o_idle    = (r_state == S_IDLE);
  assign bus.o_running = (r_state == S_RUN);
  assign bus.o_done    = (r_state == S_DONE);

endmodule

// File: tb/tb_fsm_counter.sv
// Directed and random stimulus against a timestamp-based model of the run-N-cycles sequencer.
module tb_fsm_counter;

  localparam int CW = 7;

  logic clk;
  logic reset;

  fsm_counter_if #(.CNT_WIDTH(CW)) bus ();

  fsm_counter #(.CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: an accepted op with length m_n occupies cycles m_t0 .. m_t0+m_n-1 in RUN,
  // cycle m_t0+m_n in DONE, and is over afterwards.
  bit m_active = 1'b0;
  int m_t0     = 0;
  int m_n      = 0;
  int cyc      = 0;
  int rl       = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    else
      n_pass++;
  endtask

  // 0 = idle, 1 = running, 2 = done
  function automatic int exp_phase(input int c);
    int d;
    if (!m_active) return 0;
    d = c - m_t0;
    if (d < m_n)  return 1;
    if (d == m_n) return 2;
    return 0;
  endfunction

  task automatic do_cycle(input logic run, input logic [CW-1:0] n, input logic rst);
    int ph;
    ph = exp_phase(cyc);
    if (chk_en) begin
      chk("o_idle",    32'(bus.o_idle),    32'(ph == 0));
      chk("o_running", 32'(bus.o_running), 32'(ph == 1));
      chk("o_done",    32'(bus.o_done),    32'(ph == 2));
      chk("onehot", 32'($countones({bus.o_idle, bus.o_running, bus.o_done})), 32'd1);
      if (bus.o_done === 1'b1)
        chk("run_len", 32'(rl), 32'(m_n));
    end
    if (bus.o_running === 1'b1) rl++;
    else                        rl = 0;
    bus.i_run     = run;
    bus.i_num_cnt = n;
    reset         = rst;
    @(posedge clk);
    if (rst)                     m_active = 1'b0;
    else if (ph == 0 && run) begin
      m_active = 1'b1;
      m_t0     = cyc + 1;
      m_n      = int'(n);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic repeat_cycle(input int k, input logic run, input logic [CW-1:0] n);
    for (int i = 0; i < k; i++) do_cycle(run, n, 1'b0);
  endtask

  task automatic one_op(input logic [CW-1:0] n);
    do_cycle(1'b1, n, 1'b0);
    repeat_cycle(int'(n) + 3, 1'b0, '0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.i_run     = 1'b0;
    bus.i_num_cnt = '0;
    @(negedge clk);
    do_cycle(1'b0, '0, 1'b1);
    do_cycle(1'b0, '0, 1'b1);
    chk_en = 1'b1;
    chk("reset_idle",    32'(bus.o_idle),    32'd1);
    chk("reset_running", 32'(bus.o_running), 32'd0);
    chk("reset_done",    32'(bus.o_done),    32'd0);
    repeat_cycle(2, 1'b0, 7'd55);

    one_op(7'd100);
    one_op(7'd1);
    one_op(7'd0);
    one_op(7'd127);

    // Inputs changing during RUN must not disturb the op or queue another.
    do_cycle(1'b1, 7'd10, 1'b0);
    repeat_cycle(2, 1'b0, 7'd10);
    repeat_cycle(4, 1'b1, 7'd50);
    repeat_cycle(10, 1'b0, 7'd50);

    // Reset during RUN cycle 40 aborts without a DONE pulse.
    do_cycle(1'b1, 7'd100, 1'b0);
    repeat_cycle(39, 1'b0, '0);
    chk("mid_running", 32'(bus.o_running), 32'd1);
    do_cycle(1'b0, '0, 1'b1);
    chk("abort_idle", 32'(bus.o_idle), 32'd1);
    repeat_cycle(3, 1'b0, '0);
    one_op(7'd5);

    repeat_cycle(25, 1'b1, 7'd3);
    repeat_cycle(6, 1'b0, '0);

    for (int i = 0; i < 600; i++) begin
      do_cycle(($urandom_range(0, 3) == 0),
               CW'($urandom_range(0, 20)),
               ($urandom_range(0, 149) == 0));
    end
    repeat_cycle(30, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
